lut_bs_loader: RTL and testbench

- Configuration-side initiator for the breakpoint/slope interpolation LUT. It drives the LUT's write port: conf_wr_en, conf_addr, conf_data_base, conf_data_slope.
- Host streams LUT_DEPTH+1 Q4.12 samples g[0..LUT_DEPTH] of the force kernel. The loader writes entry i with base=g[i] and slope=sat16(g[i+1]-g[i]).
- It sits between the host/config bus and the LUT, and brings up the table before any PE traffic.

---
 rtl/lut_bs_pkg.sv | 46 ++++
 rtl/lut_bs_loader.sv | 146 ++++++++++++++
 tb/tb_lut_bs_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_bs_pkg.sv
// Shared types and helpers for the breakpoint/slope LUT loader.
// Holds the loader state encoding, the Q4.12 sample type, default table
// geometry and the slope saturation function.
package lut_bs_pkg;

    // Default table geometry: 2**DEF_SEG_BITS entries.
    localparam int DEF_SEG_BITS  = 8;
    localparam int DEF_LUT_DEPTH = 256;
    localparam int DEF_CNT_WIDTH = 9;

    // Q4.12 signed fixed-point sample.
    localparam int Q_WIDTH = 16;
    typedef logic signed [Q_WIDTH-1:0] q4_12_t;

    localparam q4_12_t Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
    localparam q4_12_t Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

    // Loader states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FINISH = 2'd3
    } ld_state_t;

    // Clamped slope plus a flag telling whether clamping happened.
    typedef struct packed {
        logic   sat;
        q4_12_t val;
    } sat_res_t;

    // Clamp a one-bit-wider signed difference into the Q4.12 range.
    // The value fits exactly when the top two bits agree; otherwise the
    // sign bit tells which rail to pin to.
    function automatic sat_res_t sat16(input logic [Q_WIDTH:0] diff);
        sat_res_t r;
        r.sat = diff[Q_WIDTH] ^ diff[Q_WIDTH-1];
        if (r.sat) begin
            r.val = diff[Q_WIDTH] ? Q_MIN : Q_MAX;
        end else begin
            r.val = diff[Q_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lut_bs_loader.sv
// Breakpoint/slope LUT loader.
// Consumes LUT_DEPTH+1 Q4.12 kernel samples from the host stream and writes
// LUT entry i with base = g[i] and slope = sat16(g[i+1] - g[i]). One sample
// per cycle is sustained; each write appears the cycle after its handshake.
module lut_bs_loader
    import lut_bs_pkg::*;
#(
    parameter int SEG_BITS   = DEF_SEG_BITS,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH,
    parameter int DATA_WIDTH = Q_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         s_valid,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         s_ready,
    output logic                         conf_wr_en,
    output logic        [SEG_BITS-1:0]   conf_addr,
    output logic signed [DATA_WIDTH-1:0] conf_data_base,
    output logic signed [DATA_WIDTH-1:0] conf_data_slope,
    output logic                         busy,
    output logic                         done,
    output logic        [CNT_WIDTH-1:0]  sat_cnt
);

    localparam logic [SEG_BITS-1:0]  LAST_IDX = SEG_BITS'(LUT_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    ld_state_t                  state;
    ld_state_t                  state_nx;
    logic signed [DATA_WIDTH-1:0] prev;
    logic        [SEG_BITS-1:0]   idx;
    logic        [DATA_WIDTH:0]   diff;
    sat_res_t                     slope_res;
    logic                         load_go;
    logic                         take;
    logic                         last_idx;

    // A load begins only from IDLE, and a simultaneous abort vetoes it.
    assign load_go  = (state == ST_IDLE) && start && !abort;
    // A handshake that coincides with abort is dropped so no write follows it.
    assign take     = s_valid && s_ready && !abort;
    assign last_idx = (idx == LAST_IDX);

    // Difference formed one bit wider so it cannot wrap before clamping.
    assign diff      = {s_data[DATA_WIDTH-1], s_data} - {prev[DATA_WIDTH-1], prev};
    assign slope_res = sat16(diff);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values regardless of statement order.
            state <= state_nx;
        end
    end

    // Next-state decode; s_ready and busy depend on state only.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_nx = state;
        s_ready  = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_nx = ST_PRIME;
            end
            ST_PRIME: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (abort)        state_nx = ST_IDLE;
                else if (s_valid) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (abort)                    state_nx = ST_IDLE;
                else if (s_valid && last_idx) state_nx = ST_FINISH;
            end
            ST_FINISH: begin
                busy     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sample history, entry index and saturation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            idx     <= '0;
            sat_cnt <= '0;
        end else begin
            if (load_go) begin
                idx     <= '0;
                sat_cnt <= '0;
            end
            if (take && (state == ST_PRIME)) begin
                prev <= s_data;
            end
            if (take && (state == ST_STREAM)) begin
                prev <= s_data;
                if (!last_idx) idx <= idx + SEG_BITS'(1);
                if (slope_res.sat && (sat_cnt != CNT_MAX)) begin
                    sat_cnt <= sat_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // LUT write port: strobe for one cycle after each streaming handshake,
    // address and data held between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_wr_en      <= 1'b0;
            conf_addr       <= '0;
            conf_data_base  <= '0;
            conf_data_slope <= '0;
        end else begin
            conf_wr_en <= 1'b0;
            if (take && (state == ST_STREAM)) begin
                conf_wr_en      <= 1'b1;
                conf_addr       <= idx;
                conf_data_base  <= prev;
                conf_data_slope <= slope_res.val;
            end
        end
    end

    // Completion pulse the cycle after the final write, unless aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == ST_FINISH) && !abort;
        end
    end

endmodule

// File: tb/tb_lut_bs_loader.sv
// Scoreboard bench for lut_bs_loader. The stimulus side pushes the expected
// LUT writes and completion events; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lut_bs_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] base;
        logic [15:0] slope;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic        conf_wr_en;
    logic [7:0]  conf_addr;
    logic [15:0] conf_data_base;
    logic [15:0] conf_data_slope;
    logic        busy;
    logic        done;
    logic [8:0]  sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int last_wr_cycle = -100;
    int exp_spacing = 0;
    bit first_wr = 1'b1;

    int  g[257];
    wr_t exp_q[$];
    int  done_q[$];

    lut_bs_loader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .conf_wr_en      (conf_wr_en),
        .conf_addr       (conf_addr),
        .conf_data_base  (conf_data_base),
        .conf_data_slope (conf_data_slope),
        .busy            (busy),
        .done            (done),
        .sat_cnt         (sat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference slope: plain integer difference clamped to the Q4.12 range.
    function automatic logic [15:0] model_slope(input int a, input int b, output bit sat);
        int d;
        d   = b - a;
        sat = 1'b0;
        if (d > 32767) begin
            d = 32767;  sat = 1'b1;
        end else if (d < -32768) begin
            d = -32768; sat = 1'b1;
        end
        return d[15:0];
    endfunction

    // Monitor: every write and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (conf_wr_en) begin
                check("write_expected", 48'(exp_q.size() != 0), 48'd1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_data", 48'({conf_addr, conf_data_base, conf_data_slope}), 48'(e));
                    if (exp_spacing > 0 && !first_wr)
                        check("write_spacing", 48'(cycle - last_wr_cycle), 48'(exp_spacing));
                end
                first_wr      = 1'b0;
                last_wr_cycle = cycle;
            end
            if (done) begin
                check("done_expected", 48'(done_q.size() != 0), 48'd1);
                if (done_q.size() != 0) begin
                    int s;
                    s = done_q.pop_front();
                    check("done_sat_cnt", 48'(sat_cnt), 48'(s));
                    check("done_timing", 48'(cycle - last_wr_cycle), 48'd1);
                    check("done_busy_low", 48'(busy), 48'd0);
                    check("done_writes_drained", 48'(exp_q.size()), 48'd0);
                end
            end
        end
    end

    // Offer one sample and hold it until the loader accepts it (bounded).
    task automatic drive_sample(input int d, input bit with_start);
        int waited;
        s_valid = 1'b1;
        s_data  = d[15:0];
        start   = with_start;
        waited  = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 20) begin
                check("handshake_timeout", 48'(s_ready), 48'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    // gap < 0 selects a random 0..2 idle cycles before each sample.
    task automatic run_load(input int n_send, input int gap, input bit rand_start);
        int  sats;
        bit  s;
        wr_t w;
        sats        = 0;
        first_wr    = 1'b1;
        exp_spacing = (gap >= 0) ? gap + 1 : 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < n_send; k++) begin
            int gp;
            gp = (gap >= 0) ? gap : int'($urandom_range(2));
            if (k > 0) repeat (gp) begin @(posedge clk); #1; end
            if (k > 0) begin
                w.addr  = 8'(k - 1);
                w.base  = g[k-1][15:0];
                w.slope = model_slope(g[k-1], g[k], s);
                exp_q.push_back(w);
                if (s) sats++;
            end
            if (k == 256) done_q.push_back(sats);
            drive_sample(g[k], rand_start && ($urandom_range(7) == 0));
        end
    endtask

    task automatic wait_drain(input string name);
        repeat (4) begin @(posedge clk); #1; end
        check({name, "_writes_drained"}, 48'(exp_q.size()), 48'd0);
        check({name, "_done_seen"}, 48'(done_q.size()), 48'd0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 257; i++) g[i] = 16 * i;
    endtask

    initial begin
        // Reset state.
        #3;
        check("reset_outputs", 48'({s_ready, conf_wr_en, busy, done, conf_addr,
                                     conf_data_base, conf_data_slope, sat_cnt}), 48'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // start && abort in IDLE: nothing happens.
        start = 1'b1; abort = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_ready", 48'(s_ready), 48'd0);
        check("start_abort_idle_busy", 48'(busy), 48'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;

        // Linear ramp, continuous stream.
        fill_ramp();
        run_load(257, 0, 1'b0);
        wait_drain("ramp");

        // Same ramp, sample valid one cycle in three.
        run_load(257, 2, 1'b0);
        wait_drain("bubbles");

        // Saturation in both directions, then flat.
        g[0] = 32767; g[1] = -32768;
        for (int i = 2; i < 257; i++) g[i] = 32767;
        run_load(257, 0, 1'b0);
        wait_drain("sat");

        // Abort the cycle after the handshake that writes entry 100.
        fill_ramp();
        run_load(102, 0, 1'b0);
        abort = 1'b1; s_valid = 1'b1; s_data = g[102][15:0];
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 48'(busy), 48'd0);
        check("abort_ready", 48'(s_ready), 48'd0);
        wait_drain("abort");
        run_load(257, 0, 1'b0);
        wait_drain("after_abort");

        // Reset in the middle of a load.
        run_load(51, 0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_outputs", 48'({s_ready, conf_wr_en, busy, done, conf_addr,
                                        conf_data_base, conf_data_slope, sat_cnt}), 48'd0);
        check("midreset_queue", 48'(exp_q.size()), 48'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_load(257, 0, 1'b0);
        wait_drain("after_reset");

        // Random full-range samples, random gaps, stray start pulses.
        for (int i = 0; i < 257; i++) g[i] = int'($signed(16'($urandom)));
        run_load(257, -1, 1'b1);
        wait_drain("rand_wide");

        // Random small-step walk: no clamping expected.
        g[0] = int'($urandom_range(4000)) - 2000;
        for (int i = 1; i < 257; i++) g[i] = g[i-1] + int'($urandom_range(400)) - 200;
        run_load(257, -1, 1'b1);
        wait_drain("rand_walk");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
